// File: rtl/dump_pkg.sv
// Shared constants and FSM state type for the end-of-program register dump.
package dump_pkg;

   localparam int unsigned DUMP_NUM_REGS = 8;
   localparam int unsigned DUMP_DATA_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      FIN  = 2'd3
   } dump_state_e;

endpackage

// File: rtl/reg_dump.sv
// Walks the register file once after halt and streams (addr, data) beats out
// on a valid/ready port, raising done once the last beat has been accepted.
module reg_dump
   import dump_pkg::*;
#(
   parameter int unsigned NUM_REGS = DUMP_NUM_REGS,
   parameter int unsigned DATA_W   = DUMP_DATA_W,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              capture;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         dump_addr <= '0;
         dump_data <= '0;
         done      <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         // done is a flop that tracks the FIN state one-for-one
         done    <= (state_d == FIN);
         if (capture) begin
            dump_addr <= idx_q;
            dump_data <= rf_rdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (halt) begin
               state_d = READ;
               idx_d   = '0;
            end
         end
         READ: begin
            capture = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = READ;
               end
            end
         end
         FIN: begin
            // idx returns to 0 so the read port idles at entry 0
            if (!halt) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign rf_raddr   = idx_q;
   assign dump_valid = (state_q == SEND);
   assign busy       = (state_q == READ) || (state_q == SEND);

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: beat tables per dump plus hand-built reset,
// halt-pulse and re-arm sequences, with a per-cycle invariant monitor.
module tb_reg_dump;
   import dump_pkg::*;

   localparam int N = 8;

   typedef struct {
      int unsigned stall;
      logic [2:0]  addr;
      logic [7:0]  data;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       halt = 1'b0;
   logic       dump_ready = 1'b0;
   logic [2:0] rf_raddr, dump_addr;
   logic [7:0] rf_rdata, dump_data;
   logic       dump_valid, busy, done;

   logic [7:0] rf [N];
   beat_t      tbl [N];
   int         checks = 0;
   int         errors = 0;

   assign rf_rdata = rf[rf_raddr];

   reg_dump #(.NUM_REGS(8), .DATA_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .halt       (halt),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!dump_valid && cycles < 30) begin
         @(negedge clk);
         cycles++;
      end
      if (!dump_valid) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic load_table(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7);
      logic [7:0] vals [N];
      vals = '{v0, v1, v2, v3, v4, v5, v6, v7};
      for (int i = 0; i < N; i++) begin
         tbl[i].stall = 0;
         tbl[i].addr  = 3'(i);
         tbl[i].data  = vals[i];
      end
   endtask

   // Consumes one full dump as described by tbl; caller has already started it.
   task automatic do_dump(input int exp_lat);
      int gap;
      for (int i = 0; i < N; i++) begin
         wait_valid(gap);
         if (i == 0) check("first_latency", gap, exp_lat);
         else        check("beat_gap", gap, 1);
         check("beat_addr", dump_addr, tbl[i].addr);
         check("beat_data", dump_data, tbl[i].data);
         check("busy_in_send", busy, 1);
         if (tbl[i].stall > 0) begin
            dump_ready = 1'b0;
            for (int s = 0; s < int'(tbl[i].stall); s++) begin
               @(negedge clk);
               check("stall_valid", dump_valid, 1);
               check("stall_addr", dump_addr, tbl[i].addr);
               check("stall_data", dump_data, tbl[i].data);
            end
            dump_ready = 1'b1;
         end
         @(negedge clk);
      end
      check("done_after_last", done, 1);
      check("valid_after_last", dump_valid, 0);
      check("busy_after_last", busy, 0);
   endtask

   // Invariants sampled every cycle outside reset
   logic       prev_valid = 1'b0, prev_ready = 1'b0;
   logic [2:0] prev_addr = '0;
   logic [7:0] prev_data = '0;
   always @(negedge clk) begin
      if (reset) begin
         if (done && dump_valid) check("inv_done_and_valid", 32'd1, 32'd0);
         if (dump_addr >= 3'(N - 1) + 3'd1 && N < 8) check("inv_addr_range", dump_addr, N - 1);
         if (prev_valid && !prev_ready && dump_valid) begin
            check("inv_hold_addr", dump_addr, prev_addr);
            check("inv_hold_data", dump_data, prev_data);
         end
         prev_valid = dump_valid;
         prev_ready = dump_ready;
         prev_addr  = dump_addr;
         prev_data  = dump_data;
      end else begin
         prev_valid = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int seen;
      rf = '{8'd1, 8'd8, 8'd4, 8'd0, 8'd85, 8'd0, 8'd0, 8'd0};

      // 1. reset state and basic dump
      repeat (2) @(negedge clk);
      check("rst_valid", dump_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", dump_addr, 0);
      check("rst_data", dump_data, 0);
      check("rst_raddr", rf_raddr, 0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_no_halt", busy, 0);
      load_table(8'd1, 8'd8, 8'd4, 8'd0, 8'd85, 8'd0, 8'd0, 8'd0);
      halt = 1'b1;
      dump_ready = 1'b1;
      do_dump(2);
      repeat (2) begin
         @(negedge clk);
         check("done_held", done, 1);
         check("fin_valid_low", dump_valid, 0);
      end

      halt = 1'b0;
      @(negedge clk);
      check("done_clears", done, 0);
      check("idle_raddr", rf_raddr, 0);

      // 2. backpressure on beat 4
      load_table(8'd1, 8'd8, 8'd4, 8'd0, 8'd85, 8'd0, 8'd0, 8'd0);
      tbl[4].stall = 5;
      halt = 1'b1;
      do_dump(2);
      halt = 1'b0;
      @(negedge clk);
      check("done_clears_2", done, 0);

      // 3. single-cycle halt pulse
      load_table(8'd1, 8'd8, 8'd4, 8'd0, 8'd85, 8'd0, 8'd0, 8'd0);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      check("pulse_busy", busy, 1);
      do_dump(1);
      @(negedge clk);
      check("pulse_done_drops", done, 0);
      check("pulse_idle", busy, 0);

      // 4. reset while beat 2 is waiting in SEND
      halt = 1'b1;
      n = 0;
      while (!(dump_valid && dump_addr == 3'd2) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("reach_beat2", (dump_valid && dump_addr == 3'd2), 1);
      dump_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_valid", dump_valid, 0);
      check("async_busy", busy, 0);
      check("async_done", done, 0);
      check("async_addr", dump_addr, 0);
      @(negedge clk);
      reset = 1'b1;
      dump_ready = 1'b1;
      load_table(8'd1, 8'd8, 8'd4, 8'd0, 8'd85, 8'd0, 8'd0, 8'd0);
      do_dump(2);

      // 5. re-arm with updated register 3
      halt = 1'b0;
      @(negedge clk);
      check("rearm_idle_done", done, 0);
      rf[3] = 8'd7;
      load_table(8'd1, 8'd8, 8'd4, 8'd7, 8'd85, 8'd0, 8'd0, 8'd0);
      halt = 1'b1;
      do_dump(2);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (dump_valid) seen++;
      end
      check("no_extra_beats", seen, 0);
      check("rearm_done_held", done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
